// File: rtl/pcpi_galois_pkg.sv
// Shared encodings, FSM states and reset constants for the pcpi_galois coprocessor.
package pcpi_galois_pkg;

   localparam logic [6:0] OPCODE_R   = 7'b0110011;
   localparam logic [6:0] FUNCT7_G   = 7'b0000100;

   localparam logic [2:0] F3_CLMUL   = 3'd0;
   localparam logic [2:0] F3_GFMUL   = 3'd1;
   localparam logic [2:0] F3_CLMULH  = 3'd2;
   localparam logic [2:0] F3_GLWIDTH = 3'd4;

   localparam int unsigned M_RST = 32'd8;
   localparam int unsigned P_RST = 32'h0000_011B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RED  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/pcpi_galois_clmul.sv
// Iterative W x W carry-less multiplier: bit 0 is folded in on the start cycle,
// one further multiplier bit per cycle; o_done rises once the 2W-bit product is final.
module gf_clmul_iter #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_start,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic           o_done,
   output logic [2*W-1:0] o_prod
);

   localparam int CNTW = $clog2(W);
   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(W - 1);
   localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
   localparam logic [2*W-1:0]  PROD_ZERO = {(2*W){1'b0}};

   logic [2*W-1:0] r_a;
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_b;
   logic [CNTW-1:0] r_cnt;
   logic           r_busy;
   logic           r_done;

   // Shift-XOR accumulation, one multiplier bit per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= PROD_ZERO;
         r_acc  <= PROD_ZERO;
         r_b    <= {W{1'b0}};
         r_cnt  <= {CNTW{1'b0}};
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (i_start) begin
         r_a    <= {{(W-1){1'b0}}, i_a, 1'b0};
         r_acc  <= i_b[0] ? {{W{1'b0}}, i_a} : PROD_ZERO;
         r_b    <= {1'b0, i_b[W-1:1]};
         r_cnt  <= CNT_ONE;
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (r_busy) begin
         r_acc <= r_acc ^ (r_b[0] ? r_a : PROD_ZERO);
         r_a   <= {r_a[2*W-2:0], 1'b0};
         r_b   <= {1'b0, r_b[W-1:1]};
         r_cnt <= r_cnt + CNT_ONE;
         if (r_cnt == CNT_LAST) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign o_done = r_done;
   assign o_prod = r_acc;

endmodule

// File: rtl/pcpi_galois.sv
// PCPI coprocessor for picorv32: carry-less multiply and GF(2^m) modular multiply
// with a runtime-configurable field width/polynomial.
module pcpi_galois
   import pcpi_galois_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pcpi_valid,
   input  logic [31:0]           pcpi_insn,
   input  logic [DATA_WIDTH-1:0] pcpi_rs1,
   input  logic [DATA_WIDTH-1:0] pcpi_rs2,
   output logic                  pcpi_wr,
   output logic [DATA_WIDTH-1:0] pcpi_rd,
   output logic                  pcpi_wait,
   output logic                  pcpi_ready
);

   localparam int W  = DATA_WIDTH;
   localparam int MW = $clog2(W + 1);
   localparam int IW = $clog2(2 * W);
   localparam int CW = IW + 1;
   localparam logic [W:0]    P_ONE     = {{W{1'b0}}, 1'b1};
   localparam logic [W:0]    P_RST_W   = (W + 1)'(P_RST);
   localparam logic [MW-1:0] M_RST_W   = MW'(M_RST);
   localparam logic [IW-1:0] IDX_TOP   = IW'(2 * W - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};

   // Field width saturates at W; bit m of the polynomial is forced, bits above cleared.
   function automatic logic [MW-1:0] f_sat_m(input logic [5:0] raw);
      if (int'(raw) > W) return MW'(W);
      else return MW'(raw);
   endfunction

   function automatic logic [W:0] f_poly(input logic [MW-1:0] m, input logic [W-1:0] v);
      logic [W:0] one_hot;
      one_hot = P_ONE << m;
      return ({1'b0, v} & (one_hot - P_ONE)) | one_hot;
   endfunction

   state_t          r_state;
   logic [2:0]      r_f3;
   logic [5:0]      r_rs1_m;
   logic [W-1:0]    r_rs2;
   logic [2*W-1:0]  r_prod;
   logic [IW-1:0]   r_idx;
   logic [MW-1:0]   r_m;
   logic [W:0]      r_p;
   logic            r_armed;
   logic            r_wr;
   logic            r_ready;
   logic            r_wait;
   logic [W-1:0]    r_rd;

   logic [2:0]      w_f3;
   logic            w_hit;
   logic            w_claim;
   logic            w_start;
   logic            w_mul_done;
   logic [2*W-1:0]  w_mul_prod;
   logic [MW-1:0]   w_new_m;
   logic [W:0]      w_new_p;
   logic [CW-1:0]   w_sh;
   logic            w_red_hit;
   logic [2*W-1:0]  w_pshift;
   logic [W-1:0]    w_result;
   logic            w_unused_bits;

   assign w_f3    = pcpi_insn[14:12];
   assign w_hit   = (pcpi_insn[6:0] == OPCODE_R) && (pcpi_insn[31:25] == FUNCT7_G) &&
                    ((w_f3 == F3_CLMUL) || (w_f3 == F3_GFMUL) ||
                     (w_f3 == F3_CLMULH) || (w_f3 == F3_GLWIDTH));
   assign w_claim = pcpi_valid && w_hit && r_armed && (r_state == ST_IDLE);
   assign w_start = w_claim && (w_f3 != F3_GLWIDTH);
   assign w_unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   gf_clmul_iter #(.W(W)) u_clmul (
      .clk     (clk),
      .rst     (resetn),
      .i_start (w_start),
      .i_a     (pcpi_rs1),
      .i_b     (pcpi_rs2),
      .o_done  (w_mul_done),
      .o_prod  (w_mul_prod)
   );

   assign w_new_m   = f_sat_m(r_rs1_m);
   assign w_new_p   = f_poly(w_new_m, r_rs2);
   // Reduction step: cancel product bit r_idx with P aligned so its leading term lands there
   assign w_sh      = CW'(r_idx) - CW'(r_m);
   assign w_red_hit = r_prod[r_idx] && (CW'(r_idx) >= CW'(r_m));
   assign w_pshift  = {{(W-1){1'b0}}, r_p} << w_sh;

   // Result selection for the completing instruction
   always_comb begin
      w_result = r_prod[W-1:0];
      case (r_f3)
         F3_CLMULH:  w_result = r_prod[2*W-1:W];
         F3_GLWIDTH: w_result = w_new_p[W-1:0];
         default:    w_result = r_prod[W-1:0];
      endcase
   end

   // Control FSM, reduction datapath, field configuration and registered PCPI outputs
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_state <= ST_IDLE;
         r_f3    <= 3'd0;
         r_rs1_m <= 6'd0;
         r_rs2   <= {W{1'b0}};
         r_prod  <= {(2*W){1'b0}};
         r_idx   <= IDX_ZERO;
         r_m     <= M_RST_W;
         r_p     <= P_RST_W;
         r_armed <= 1'b1;
         r_wr    <= 1'b0;
         r_ready <= 1'b0;
         r_wait  <= 1'b0;
         r_rd    <= {W{1'b0}};
      end else if ((r_state != ST_IDLE) && !pcpi_valid) begin
         r_state <= ST_IDLE;
         r_wait  <= 1'b0;
         r_armed <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b0;
               r_wr    <= 1'b0;
               if (!pcpi_valid) begin
                  r_armed <= 1'b1;
               end else if (w_claim) begin
                  r_f3    <= w_f3;
                  r_rs1_m <= pcpi_rs1[5:0];
                  r_rs2   <= pcpi_rs2;
                  r_wait  <= 1'b1;
                  r_state <= (w_f3 == F3_GLWIDTH) ? ST_DONE : ST_MUL;
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_prod  <= w_mul_prod;
                  r_idx   <= IDX_TOP;
                  r_state <= (r_f3 == F3_GFMUL) ? ST_RED : ST_DONE;
               end
            end
            ST_RED: begin
               if (w_red_hit) begin
                  r_prod <= r_prod ^ w_pshift;
               end
               r_idx <= r_idx - IDX_ONE;
               if (r_idx == IDX_ZERO) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ready <= 1'b1;
               r_wr    <= 1'b1;
               r_wait  <= 1'b0;
               r_rd    <= w_result;
               r_armed <= 1'b0;
               r_state <= ST_IDLE;
               if (r_f3 == F3_GLWIDTH) begin
                  r_m <= w_new_m;
                  r_p <= w_new_p;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign pcpi_wr    = r_wr;
   assign pcpi_rd    = r_rd;
   assign pcpi_wait  = r_wait;
   assign pcpi_ready = r_ready;

endmodule

// File: tb/tb_pcpi_galois.sv
// Randomized self-checking bench for pcpi_galois against a polynomial-arithmetic model.
module tb_pcpi_galois;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          pcpi_valid;
   logic [31:0]   pcpi_insn;
   logic [W-1:0]  pcpi_rs1;
   logic [W-1:0]  pcpi_rs2;
   logic          pcpi_wr;
   logic [W-1:0]  pcpi_rd;
   logic          pcpi_wait;
   logic          pcpi_ready;

   int n_cmp = 0;
   int n_bad = 0;

   int          mdl_m;
   logic [63:0] mdl_p;
   logic [31:0] last_rd;
   logic [2:0]  f3_tbl [4];

   pcpi_galois #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_rs1   (pcpi_rs1),
      .pcpi_rs2   (pcpi_rs2),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (pcpi_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Polynomial product over GF(2)
   function automatic logic [63:0] ref_clmul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = 64'h0;
      for (int i = 0; i < 32; i++)
         if (b[i]) r = r ^ ({32'h0, a} << i);
      return r;
   endfunction

   function automatic int ref_deg(input logic [63:0] x);
      for (int i = 63; i >= 0; i--)
         if (x[i]) return i;
      return -1;
   endfunction

   // Polynomial remainder: cancel the leading term until degree drops below m
   function automatic logic [31:0] ref_mod(input logic [63:0] x, input int m, input logic [63:0] p);
      logic [63:0] r;
      r = x;
      while (ref_deg(r) >= m) r = r ^ (p << (ref_deg(r) - m));
      return r[31:0];
   endfunction

   function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      logic [4:0] r1, r2, rd;
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      return {f7, r2, r1, f3, rd, op};
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] rd);
      int          nm;
      logic [63:0] np;
      logic [63:0] one;
      logic [63:0] prod;
      logic [31:0] exp;
      int          lat_exp;
      int          cyc;
      bit          got_ready;
      bit          wait_ok;
      prod = ref_clmul(a, b);
      nm   = mdl_m;
      np   = mdl_p;
      case (f3)
         3'd0: begin exp = prod[31:0];  lat_exp = W + 2; end
         3'd2: begin exp = prod[63:32]; lat_exp = W + 2; end
         3'd1: begin exp = ref_mod(prod, mdl_m, mdl_p); lat_exp = 3 * W + 2; end
         default: begin
            nm  = int'(a[5:0]);
            if (nm > W) nm = W;
            one = 64'h1 << nm;
            np  = ({32'h0, b} & (one - 64'h1)) | one;
            exp = np[31:0];
            lat_exp = 2;
         end
      endcase
      @(negedge clk);
      pcpi_insn  = mk_insn(7'b0000100, f3, 7'b0110011);
      pcpi_rs1   = a;
      pcpi_rs2   = b;
      pcpi_valid = 1'b1;
      cyc = 0;
      got_ready = 1'b0;
      wait_ok = 1'b1;
      while (!got_ready && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (pcpi_ready) got_ready = 1'b1;
         else if (!pcpi_wait) wait_ok = 1'b0;
      end
      chk({tag, "_ready"}, 64'(got_ready), 64'd1);
      chk({tag, "_latency"}, 64'(cyc), 64'(lat_exp));
      chk({tag, "_rd"}, 64'(pcpi_rd), 64'(exp));
      chk({tag, "_wr"}, 64'(pcpi_wr), 64'd1);
      chk({tag, "_wait_at_ready"}, 64'(pcpi_wait), 64'd0);
      chk({tag, "_wait_held"}, 64'(wait_ok), 64'd1);
      rd = pcpi_rd;
      if (got_ready && f3 == 3'd4) begin
         mdl_m = nm;
         mdl_p = np;
      end
      @(posedge clk); #1;
      chk({tag, "_no_reclaim"}, 64'({pcpi_wait, pcpi_ready, pcpi_wr}), 64'd0);
      pcpi_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rd_hold"}, 64'(pcpi_rd), 64'(exp));
      last_rd = exp;
   endtask

   task automatic run_ignored(input string tag, input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      bit seen;
      @(negedge clk);
      pcpi_insn  = mk_insn(f7, f3, op);
      pcpi_rs1   = $urandom;
      pcpi_rs2   = $urandom;
      pcpi_valid = 1'b1;
      seen = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (pcpi_wait || pcpi_ready || pcpi_wr) seen = 1'b1;
      end
      chk({tag, "_quiet"}, 64'(seen), 64'd0);
      chk({tag, "_rd_hold"}, 64'(pcpi_rd), 64'(last_rd));
      pcpi_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a, b;
      logic [2:0]  f3;
      bit          seen;
      f3_tbl[0] = 3'd0; f3_tbl[1] = 3'd1; f3_tbl[2] = 3'd2; f3_tbl[3] = 3'd4;
      mdl_m = 8; mdl_p = 64'h11B; last_rd = 32'h0;
      resetn = 1'b1; pcpi_valid = 1'b0; pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 64'({pcpi_wait, pcpi_ready, pcpi_wr}), 64'd0);
      chk("reset_rd", 64'(pcpi_rd), 64'd0);
      resetn = 1'b0;
      @(posedge clk); #1;

      // Known values from the field definitions
      run_op("clmul_e_f", 3'd0, 32'hE, 32'hF, rd);          chk("clmul_e_f_const", 64'(rd), 64'h5A);
      run_op("clmulh_e_f", 3'd2, 32'hE, 32'hF, rd);         chk("clmulh_e_f_const", 64'(rd), 64'h0);
      run_op("clmulh_msb", 3'd2, 32'h80000000, 32'h80000000, rd); chk("clmulh_msb_const", 64'(rd), 64'h40000000);
      run_op("clmul_msb", 3'd0, 32'h80000000, 32'h80000000, rd);  chk("clmul_msb_const", 64'(rd), 64'h0);
      run_op("gf_aes", 3'd1, 32'h57, 32'h83, rd);           chk("gf_aes_const", 64'(rd), 64'hC1);
      run_op("glw_4", 3'd4, 32'h4, 32'h13, rd);             chk("glw_4_const", 64'(rd), 64'h13);
      run_op("gf4_a", 3'd1, 32'h1, 32'h5A, rd);             chk("gf4_a_const", 64'(rd), 64'h5);
      run_op("gf4_b", 3'd1, 32'h2, 32'h9, rd);              chk("gf4_b_const", 64'(rd), 64'h1);
      run_op("gf4_c", 3'd1, 32'h13, 32'h5A, rd);            chk("gf4_c_const", 64'(rd), 64'h0);

      // Field-width boundaries: m=0 and saturation to W
      run_op("glw_0", 3'd4, 32'h0, $urandom, rd);           chk("glw_0_const", 64'(rd), 64'h1);
      run_op("gf_m0", 3'd1, $urandom, $urandom, rd);        chk("gf_m0_const", 64'(rd), 64'h0);
      run_op("glw_sat", 3'd4, 32'h3F, 32'hFFFFFFFF, rd);    chk("glw_sat_const", 64'(rd), 64'hFFFFFFFF);
      run_op("gf_m32", 3'd1, $urandom, $urandom, rd);

      // Non-matching encodings must be left alone
      run_ignored("ign_f3_3", 7'b0000100, 3'd3, 7'b0110011);
      run_ignored("ign_f7", 7'b0000001, 3'd0, 7'b0110011);
      run_ignored("ign_op", 7'b0000100, 3'd1, 7'b0110111);

      for (int n = 0; n < 30; n++) begin
         f3 = f3_tbl[$urandom_range(0, 3)];
         a  = $urandom;
         b  = $urandom;
         if (f3 == 3'd4) a = 32'($urandom_range(0, 40));
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         run_op($sformatf("rnd%0d_f%0d", n, f3), f3, a, b, rd);
      end

      // Abort during MUL: no ready, rd unchanged, next op correct
      @(negedge clk);
      pcpi_insn = mk_insn(7'b0000100, 3'd0, 7'b0110011);
      pcpi_rs1 = $urandom; pcpi_rs2 = $urandom; pcpi_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_mul_busy", 64'(pcpi_wait), 64'd1);
      pcpi_valid = 1'b0;
      seen = 1'b0;
      repeat (120) begin
         @(posedge clk); #1;
         if (pcpi_ready || pcpi_wr) seen = 1'b1;
      end
      chk("abort_mul_no_ready", 64'(seen), 64'd0);
      chk("abort_mul_wait_low", 64'(pcpi_wait), 64'd0);
      chk("abort_mul_rd_hold", 64'(pcpi_rd), 64'(last_rd));
      run_op("after_abort", 3'd0, $urandom, $urandom, rd);

      // Abort GLWIDTH before completion: configuration must not change
      @(negedge clk);
      pcpi_insn = mk_insn(7'b0000100, 3'd4, 7'b0110011);
      pcpi_rs1 = 32'h5; pcpi_rs2 = 32'h25; pcpi_valid = 1'b1;
      @(posedge clk); #1;
      chk("abort_glw_busy", 64'(pcpi_wait), 64'd1);
      pcpi_valid = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (pcpi_ready) seen = 1'b1;
      end
      chk("abort_glw_no_ready", 64'(seen), 64'd0);
      run_op("after_glw_abort", 3'd1, $urandom, $urandom, rd);

      // Reset pulse mid-operation restores the AES field
      run_op("glw_7", 3'd4, 32'h7, 32'h83, rd);
      @(negedge clk);
      pcpi_insn = mk_insn(7'b0000100, 3'd1, 7'b0110011);
      pcpi_rs1 = 32'h57; pcpi_rs2 = 32'h83; pcpi_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b1;
      #1;
      chk("midrst_outs", 64'({pcpi_wait, pcpi_ready, pcpi_wr}), 64'd0);
      chk("midrst_rd", 64'(pcpi_rd), 64'd0);
      pcpi_valid = 1'b0;
      mdl_m = 8; mdl_p = 64'h11B; last_rd = 32'h0;
      @(posedge clk); #1;
      resetn = 1'b0;
      seen = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (pcpi_ready || pcpi_wait) seen = 1'b1;
      end
      chk("midrst_quiet", 64'(seen), 64'd0);
      run_op("gf_aes_again", 3'd1, 32'h57, 32'h83, rd);    chk("gf_aes_again_const", 64'(rd), 64'hC1);
      run_op("clmul_after_rst", 3'd0, $urandom, $urandom, rd);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
